peripheral_bus: RTL

PERIPHERAL_BUS -- requirements
Module: peripheral_bus

---
 rtl/peripheral_bus.sv | 107 ++++++++++
 1 files changed

// File: rtl/peripheral_bus.sv
// Memory-mapped peripheral block: reload timer with interrupt, LEDs, switches.
// Optional free-running SYSTICK counter at offset 0x14 when SYSTICK_EN is defined.
module peripheral_bus #(
    parameter logic [31:0] BASE_ADDR = 32'h40000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] iMemAddr,
    input  logic        iMemRead,
    input  logic        iMemWrite,
    input  logic [31:0] iMemWriteData,
    output logic [31:0] oMemReadData,
    output logic        oInterrupt,
    output logic [7:0]  oLED,
    input  logic [7:0]  iSwitch
);

    localparam logic [29:0] BaseWord = BASE_ADDR[31:2];

    logic [31:0] th;
    logic [31:0] tl;
    logic [2:0]  tcon;
    logic [7:0]  led;
`ifdef SYSTICK_EN
    logic [31:0] systick;
`endif

    logic [29:0] wordOff;
    logic        wrTh;
    logic        wrTl;
    logic        wrTcon;
    logic        wrLed;
    logic        tlOverflow;
    logic        irqSet;
    logic        unusedAddrBits;

    assign unusedAddrBits = ^iMemAddr[1:0];

    // Addresses below the base wrap to a large offset and fall out of the map.
    assign wordOff = iMemAddr[31:2] - BaseWord;

    assign wrTh   = iMemWrite && (wordOff == 30'd0);
    assign wrTl   = iMemWrite && (wordOff == 30'd1);
    assign wrTcon = iMemWrite && (wordOff == 30'd2);
    assign wrLed  = iMemWrite && (wordOff == 30'd3);

    assign tlOverflow = tcon[0] && (tl == 32'hFFFFFFFF);
    assign irqSet     = tlOverflow && tcon[1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            th   <= 32'd0;
            tl   <= 32'd0;
            tcon <= 3'd0;
            led  <= 8'd0;
        end else begin
            if (wrTh) begin
                th <= iMemWriteData;
            end
            if (wrLed) begin
                led <= iMemWriteData[7:0];
            end
            if (wrTl) begin
                tl <= iMemWriteData;
            end else if (tcon[0]) begin
                tl <= tlOverflow ? th : tl + 32'd1;
            end
            // A concurrent overflow forces the status bit so no interrupt is lost.
            if (wrTcon) begin
                tcon <= {iMemWriteData[2] | irqSet, iMemWriteData[1:0]};
            end else if (irqSet) begin
                tcon[2] <= 1'b1;
            end
        end
    end

`ifdef SYSTICK_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            systick <= 32'd0;
        end else begin
            systick <= systick + 32'd1;
        end
    end
`endif

    always_comb begin
        oMemReadData = 32'd0;
        if (iMemRead) begin
            case (wordOff)
                30'd0:   oMemReadData = th;
                30'd1:   oMemReadData = tl;
                30'd2:   oMemReadData = {29'd0, tcon};
                30'd3:   oMemReadData = {24'd0, led};
                30'd4:   oMemReadData = {24'd0, iSwitch};
`ifdef SYSTICK_EN
                30'd5:   oMemReadData = systick;
`endif
                default: oMemReadData = 32'd0;
            endcase
        end
    end

    assign oInterrupt = tcon[1] & tcon[2];
    assign oLED       = led;

endmodule
